// File: rtl/mnacidpro_pkg.sv
// Shared types and tables for the nucleic-acid extraction sequencer.
// Holds the state enum, valve-line bit ordering and pump pattern table.
package mnacidpro_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LYSIS,
    S_WASH,
    S_ELUTE,
    S_COLLECT
  } state_e;

  localparam int NV      = 10;
  localparam int V_LYSIS = 0;
  localparam int V_WASH  = 1;
  localparam int V_ELUTE = 2;
  localparam int V_HORIZ = 3;
  localparam int V_VERT  = 4;
  localparam int V_LOOP  = 5;
  localparam int V_BVTL  = 6;
  localparam int V_BTRAP = 7;
  localparam int V_COLL  = 8;
  localparam int V_DEAD  = 9;

  localparam logic [2:0] PUMP_HOLD = 3'b111;

  function automatic logic [2:0] pump_pat(input logic [2:0] step);
    logic [2:0] p;
    unique case (step)
      3'd0:    p = 3'b011;
      3'd1:    p = 3'b001;
      3'd2:    p = 3'b101;
      3'd3:    p = 3'b100;
      3'd4:    p = 3'b110;
      3'd5:    p = 3'b010;
      default: p = PUMP_HOLD;
    endcase
    return p;
  endfunction

  // 1 = pressurised/closed; each state clears only the lines it opens
  function automatic logic [NV-1:0] valve_ctl(input state_e s);
    logic [NV-1:0] m;
    m = '1;
    unique case (s)
      S_LOAD: begin
        m[V_HORIZ] = 1'b0;
        m[V_VERT]  = 1'b0;
        m[V_DEAD]  = 1'b0;
      end
      S_LYSIS: begin
        m[V_LYSIS] = 1'b0;
        m[V_HORIZ] = 1'b0;
        m[V_LOOP]  = 1'b0;
      end
      S_WASH: begin
        m[V_WASH]  = 1'b0;
        m[V_VERT]  = 1'b0;
        m[V_BVTL]  = 1'b0;
        m[V_DEAD]  = 1'b0;
      end
      S_ELUTE: begin
        m[V_ELUTE] = 1'b0;
        m[V_VERT]  = 1'b0;
        m[V_BVTL]  = 1'b0;
      end
      S_COLLECT: begin
        m[V_COLL]  = 1'b0;
        m[V_BTRAP] = 1'b0;
      end
      default: m = '1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mnacidpro_pump_seq.sv
// Peristaltic pump stepper: divider, step counter, direction, pattern.
// Output is registered and reflects the step of the upcoming cycle.
module mnacidpro_pump_seq
  import mnacidpro_pkg::*;
#(
  parameter int PUMP_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entry_i,
  input  logic       run_i,
  input  logic       rev_i,
  output logic [2:0] pump_o
);

  localparam int DW = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic [2:0]    step_q, step_d;
  logic [2:0]    pump_q, pump_d;

  always_comb begin
    div_d  = div_q;
    step_d = step_q;
    if (entry_i || !run_i) begin
      div_d  = '0;
      step_d = '0;
    end else if (div_q == DW'(PUMP_DIV - 1)) begin
      div_d = '0;
      if (rev_i)
        step_d = (step_q == 3'd0) ? 3'd5 : step_q - 3'd1;
      else
        step_d = (step_q == 3'd5) ? 3'd0 : step_q + 3'd1;
    end else begin
      div_d = div_q + 1'b1;
    end
    pump_d = run_i ? pump_pat(step_d) : PUMP_HOLD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      step_q <= '0;
      pump_q <= PUMP_HOLD;
    end else begin
      div_q  <= div_d;
      step_q <= step_d;
      pump_q <= pump_d;
    end
  end

  assign pump_o = pump_q;

endmodule

// File: rtl/mnacidpro_seq.sv
// Extraction run sequencer: LOAD, LYSIS, WASH xN, ELUTE, COLLECT.
// Outputs are registered from next-state so they match the state's first cycle.
module mnacidpro_seq
  import mnacidpro_pkg::*;
#(
  parameter int T_LOAD    = 16,
  parameter int T_LYSIS   = 64,
  parameter int T_WASH    = 32,
  parameter int N_WASH    = 2,
  parameter int T_ELUTE   = 32,
  parameter int T_COLLECT = 8,
  parameter int PUMP_DIV  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       lysis_ctl,
  output logic       wash_ctl,
  output logic       elute_ctl,
  output logic       horiz_ctl,
  output logic       vertical_ctl,
  output logic       loop_exit_ctl,
  output logic       bead_vtl_ctl,
  output logic       bead_trap_ctl,
  output logic       collection_ctl,
  output logic       dead_end_ctl,
  output logic       pump1,
  output logic       pump2,
  output logic       pump3,
  output logic [3:0] wash_pass
);

  localparam int TM1  = (T_LOAD > T_LYSIS) ? T_LOAD : T_LYSIS;
  localparam int TM2  = (T_WASH > T_ELUTE) ? T_WASH : T_ELUTE;
  localparam int TM3  = (TM1 > TM2) ? TM1 : TM2;
  localparam int TMAX = (TM3 > T_COLLECT) ? TM3 : T_COLLECT;
  localparam int CW   = $clog2(TMAX + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      wp_q, wp_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            abrt_q, abrt_d;
  logic [NV-1:0]   ctl_q, ctl_d;
  logic            entry;
  logic            pump_run;
  logic [2:0]      pump;

  function automatic logic [CW-1:0] dwell(input state_e s);
    logic [CW-1:0] d;
    unique case (s)
      S_LOAD:    d = CW'(T_LOAD - 1);
      S_LYSIS:   d = CW'(T_LYSIS - 1);
      S_WASH:    d = CW'(T_WASH - 1);
      S_ELUTE:   d = CW'(T_ELUTE - 1);
      S_COLLECT: d = CW'(T_COLLECT - 1);
      default:   d = '0;
    endcase
    return d;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wp_d    = wp_q;
    done_d  = 1'b0;
    abrt_d  = 1'b0;
    entry   = 1'b0;
    if (state_q == S_IDLE) begin
      if (start && !abort) begin
        state_d = S_LOAD;
        entry   = 1'b1;
      end
    end else if (abort) begin
      state_d = S_IDLE;
      abrt_d  = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      entry = 1'b1;
      unique case (state_q)
        S_LOAD:  state_d = S_LYSIS;
        S_LYSIS: state_d = S_WASH;
        S_WASH: begin
          // another pass re-enters WASH with a fresh dwell and pump
          if (wp_q == 4'(N_WASH - 1)) state_d = S_ELUTE;
          else wp_d = wp_q + 4'd1;
        end
        S_ELUTE: state_d = S_COLLECT;
        default: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          entry   = 1'b0;
        end
      endcase
    end
    if (entry) cnt_d = dwell(state_d);
    if (state_d == S_IDLE) cnt_d = '0;
    if (state_d != S_WASH) wp_d = '0;
    busy_d = (state_d != S_IDLE);
    ctl_d  = valve_ctl(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wp_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abrt_q  <= 1'b0;
      ctl_q   <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wp_q    <= wp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abrt_q  <= abrt_d;
      ctl_q   <= ctl_d;
    end
  end

  assign pump_run = (state_d == S_LOAD) || (state_d == S_LYSIS)
                 || (state_d == S_WASH) || (state_d == S_ELUTE);

  mnacidpro_pump_seq #(
    .PUMP_DIV(PUMP_DIV)
  ) u_pump (
    .clk    (clk),
    .rst    (rst),
    .entry_i(entry),
    .run_i  (pump_run),
    .rev_i  (state_d == S_ELUTE),
    .pump_o (pump)
  );

  assign busy           = busy_q;
  assign done           = done_q;
  assign aborted        = abrt_q;
  assign wash_pass      = wp_q;
  assign lysis_ctl      = ctl_q[V_LYSIS];
  assign wash_ctl       = ctl_q[V_WASH];
  assign elute_ctl      = ctl_q[V_ELUTE];
  assign horiz_ctl      = ctl_q[V_HORIZ];
  assign vertical_ctl   = ctl_q[V_VERT];
  assign loop_exit_ctl  = ctl_q[V_LOOP];
  assign bead_vtl_ctl   = ctl_q[V_BVTL];
  assign bead_trap_ctl  = ctl_q[V_BTRAP];
  assign collection_ctl = ctl_q[V_COLL];
  assign dead_end_ctl   = ctl_q[V_DEAD];
  assign pump1          = pump[2];
  assign pump2          = pump[1];
  assign pump3          = pump[0];

endmodule

// File: tb/tb_mnacidpro_seq.sv
// Scoreboard bench for mnacidpro_seq with short dwell parameters.
// Vector: {busy,done,aborted, 10 ctl lines, pump1..3, wash_pass}.
module tb_mnacidpro_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done, aborted;
  logic lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl;
  logic loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl;
  logic collection_ctl, dead_end_ctl;
  logic pump1, pump2, pump3;
  logic [3:0] wash_pass;
  logic [19:0] got;

  logic [19:0] eq[$];
  string       nq[$];
  int checks   = 0;
  int failures = 0;

  localparam logic [19:0] V_IDLE = {3'b000, 10'h3ff, 3'b111, 4'd0};
  localparam logic [19:0] V_DONE = {3'b010, 10'h3ff, 3'b111, 4'd0};
  localparam logic [19:0] V_ABRT = {3'b001, 10'h3ff, 3'b111, 4'd0};

  mnacidpro_seq #(
    .T_LOAD(4), .T_LYSIS(6), .T_WASH(3), .N_WASH(2),
    .T_ELUTE(5), .T_COLLECT(2), .PUMP_DIV(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted),
    .lysis_ctl(lysis_ctl), .wash_ctl(wash_ctl),
    .elute_ctl(elute_ctl), .horiz_ctl(horiz_ctl),
    .vertical_ctl(vertical_ctl), .loop_exit_ctl(loop_exit_ctl),
    .bead_vtl_ctl(bead_vtl_ctl), .bead_trap_ctl(bead_trap_ctl),
    .collection_ctl(collection_ctl), .dead_end_ctl(dead_end_ctl),
    .pump1(pump1), .pump2(pump2), .pump3(pump3),
    .wash_pass(wash_pass)
  );

  always #5 clk = ~clk;

  assign got = {busy, done, aborted,
                lysis_ctl, wash_ctl, elute_ctl, horiz_ctl,
                vertical_ctl, loop_exit_ctl, bead_vtl_ctl,
                bead_trap_ctl, collection_ctl, dead_end_ctl,
                pump1, pump2, pump3, wash_pass};

  // Expected vector for cycle k (0..22) of a normal run
  function automatic logic [19:0] exp_run(input int k);
    int dw[6];
    int pid[6];
    logic [9:0] opn[6];
    logic [2:0] pat[6];
    int off, i, p, st;
    logic [2:0] pmp;
    dw  = '{4, 6, 3, 3, 5, 2};
    pid = '{1, 2, 3, 3, 4, 5};
    opn = '{10'b0000000000, 10'b0001100001, 10'b1001010000,
            10'b0100101001, 10'b0010101000, 10'b0000000110};
    pat = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};
    off = k;
    i = 0;
    for (int j = 0; j < 6; j++)
      if (i == j && off >= dw[j]) begin
        off -= dw[j];
        i = j + 1;
      end
    p = pid[i];
    if (p == 5) pmp = 3'b111;
    else begin
      st = (off / 2) % 6;
      if (p == 4) st = (6 - st) % 6;
      pmp = pat[st];
    end
    return {3'b100, ~opn[p], pmp, (i == 3) ? 4'd1 : 4'd0};
  endfunction

  task automatic chk(input string n, input logic [19:0] a,
                     input logic [19:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", n, a, e);
    end
  endtask

  always @(negedge clk)
    if (eq.size() > 0) chk(nq.pop_front(), got, eq.pop_front());

  task automatic step(input logic s, input logic a,
                      input logic [19:0] e, input string n);
    start = s;
    abort = a;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    eq.push_back(e);
    nq.push_back(n);
  endtask

  task automatic full_run(input int r, input bit wash_start);
    step(1'b1, 1'b0, exp_run(0), $sformatf("r%0d_c0", r));
    for (int k = 1; k < 23; k++)
      step(wash_start && k == 11, 1'b0, exp_run(k),
           $sformatf("r%0d_c%0d", r, k));
    step(1'b0, 1'b0, V_DONE, $sformatf("r%0d_done", r));
    step(1'b0, 1'b0, V_IDLE, $sformatf("r%0d_idle", r));
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 chk("reset", got, V_IDLE);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, V_IDLE, "idle0");

    full_run(1, 1'b0);

    step(1'b1, 1'b1, V_IDLE, "start_abort");
    step(1'b0, 1'b0, V_IDLE, "start_abort_hold");

    full_run(2, 1'b1);

    step(1'b1, 1'b0, exp_run(0), "ab_c0");
    for (int k = 1; k < 6; k++)
      step(1'b0, 1'b0, exp_run(k), $sformatf("ab_c%0d", k));
    step(1'b0, 1'b1, V_ABRT, "ab_pulse");
    step(1'b0, 1'b0, V_IDLE, "ab_after1");
    step(1'b0, 1'b0, V_IDLE, "ab_after2");

    step(1'b1, 1'b0, exp_run(0), "rs_c0");
    for (int k = 1; k < 20; k++)
      step(1'b0, 1'b0, exp_run(k), $sformatf("rs_c%0d", k));
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("rst_async", got, V_IDLE);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, V_IDLE, "rs_idle");
    full_run(3, 1'b0);

    @(negedge clk);
    #1;
    if (eq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain left=%0d need=0", eq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mnacidpro_seq.md
MNACIDPRO_SEQ -- requirements
Module: mnacidpro_seq

Interface
REQ-001 SHALL have parameter T_LOAD, default 16, meaning cell-load dwell in cycles (>=1).
REQ-002 SHALL have parameter T_LYSIS, default 64, meaning lysis dwell in cycles (>=1).
REQ-003 SHALL have parameter T_WASH, default 32, meaning dwell of one wash pass in cycles (>=1).
REQ-004 SHALL have parameter N_WASH, default 2, meaning wash pass count (1..15).
REQ-005 SHALL have parameter T_ELUTE, default 32, meaning elute dwell in cycles (>=1).
REQ-006 SHALL have parameter T_COLLECT, default 8, meaning collect dwell in cycles (>=1).
REQ-007 SHALL have parameter PUMP_DIV, default 4, meaning cycles per pump step (>=1).
REQ-008 SHALL have port clk, input, 1, the single clock.
REQ-009 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-010 SHALL have port start, input, 1, meaning run request, sampled in IDLE only.
REQ-011 SHALL have port abort, input, 1, meaning stop the run immediately.
REQ-012 SHALL have port busy, output, 1, meaning a run is in progress.
REQ-013 SHALL have port done, output, 1, meaning one-cycle pulse on normal completion.
REQ-014 SHALL have port aborted, output, 1, meaning one-cycle pulse on abort.
REQ-015 SHALL have ports lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl, loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl and dead_end_ctl, each output, 1, meaning valve pneumatic line (1 = pressurised/closed).
REQ-016 SHALL have ports pump1, pump2 and pump3, each output, 1, meaning peristaltic pump valve lines (1 = closed).
REQ-017 SHALL have port wash_pass, output, 4, meaning current wash pass index (0-based).

Function
REQ-018 SHALL implement the FSM IDLE -> LOAD -> LYSIS -> WASH -> ELUTE -> COLLECT -> IDLE.
REQ-019 SHALL make each state last exactly its T_* cycles, counted by a single dwell counter that reloads on every state entry.
REQ-020 SHALL repeat WASH N_WASH times back-to-back, reloading the dwell counter and incrementing wash_pass per pass; total WASH time is N_WASH*T_WASH.
REQ-021 SHALL leave IDLE on start=1 with LOAD as the first state on the next cycle; start SHALL be ignored outside IDLE.
REQ-022 SHALL register all outputs so that their values correspond to the current state in its first cycle (decoded from next-state).
REQ-023 SHALL open (drive 0) only the listed lines per state, all other ctl lines being 1:
  - IDLE: none.
  - LOAD: horiz, vertical, dead_end.
  - LYSIS: lysis, horiz, loop_exit.
  - WASH: wash, vertical, bead_vtl, dead_end.
  - ELUTE: elute, vertical, bead_vtl.
  - COLLECT: collection, bead_trap.
REQ-024 SHALL run the pump in LOAD, LYSIS, WASH and ELUTE, and hold it at pump1..3 = 111 in IDLE and COLLECT.
REQ-025 SHALL use the pump pattern {pump1,pump2,pump3}, step0..5 = 011, 001, 101, 100, 110, 010.
REQ-026 SHALL advance the pump one step every PUMP_DIV cycles, wrapping 5 -> 0, stepping forward in LOAD/LYSIS/WASH and in reverse (wrapping 0 -> 5) in ELUTE.
REQ-027 SHALL reset the pump step to 0 and the divider to 0 on each state entry, including each new wash pass.
REQ-028 SHALL hold busy=1 from the first LOAD cycle through the last COLLECT cycle.
REQ-029 SHALL pulse done for the single cycle after COLLECT, coincident with the return to IDLE.
REQ-030 SHALL, on abort=1 in any non-IDLE state, enter IDLE on the next edge with all outputs at IDLE values, pulse aborted, and not pulse done.
REQ-031 SHALL treat abort=1 in IDLE as having no effect, with abort winning over a simultaneous start.
REQ-032 SHALL hold wash_pass at 0 outside WASH.

Reset
REQ-033 SHALL, on asynchronous assertion of rst, force state IDLE, all ctl lines and pump1..3 to 1, busy/done/aborted/wash_pass to 0, and counters to 0.
REQ-034 SHALL discard any run in progress when rst asserts mid-run, with no done or aborted pulse; release is synchronous to clk.

Structure
REQ-035 SHALL place the state enum, the pump pattern table and the valve-line bit ordering in shared package mnacidpro_pkg.
REQ-036 SHALL implement the pump stepper (divider, step counter, direction, pattern lookup) as sub-module mnacidpro_pump_seq.

Verification (parameters T_LOAD=4, T_LYSIS=6, T_WASH=3, N_WASH=2, T_ELUTE=5, T_COLLECT=2, PUMP_DIV=2)
REQ-037 SHALL verify: start pulse in IDLE -> busy=1 for exactly 23 cycles, state dwells 4/6/3/3/5/2, done pulses once afterwards.
REQ-038 SHALL verify: pump in LOAD -> 011,011,001,001; in ELUTE -> 011,011,010,010,110.
REQ-039 SHALL verify: valve lines checked every cycle against the REQ-023 table; wash_pass reads 0,0,0,1,1,1 over WASH.
REQ-040 SHALL verify: abort in cycle 2 of LYSIS -> next cycle IDLE, all ctl/pump=1, aborted pulse, no done.
REQ-041 SHALL verify: start and abort together in IDLE -> remains IDLE; start during WASH -> ignored, timing unchanged.
REQ-042 SHALL verify: rst asserted mid-ELUTE without a clock edge -> outputs reach reset values immediately; a later start runs the full 23-cycle sequence.
